bcd_to_bin: RTL
===============

// Module: bcd_to_bin
// PURPOSE
//  Sequential BCD-to-binary converter using reverse double-dabble (shift-right / subtract-3).
//  Inverse of the team's binary-to-BCD converter: same start/done/rdy handshake, one result bit per CALC cycle.
//  Sits between keypad/display-side BCD logic and binary datapaths (counters, timers, ALU operands).
// PARAMETERS
//  BCD_DIGITS  4   number of packed 4-bit BCD input digits
//  BIN_DIGITS  localparam = (BCD_DIGITS*3322 + 999)/1000 (ceil of BCD_DIGITS*log2(10)); 4 -> 14
//  CNT_W       localparam = $clog2(BIN_DIGITS+1), width of the shift counter
// PORTS
//  clk      in   1               clock, rising edge
//  arst_n   in   1               reset, asynchronous, active-low
//  start    in   1               conversion request, sampled only in IDLE
//  bcd_in   in   [BCD_DIGITS-1:0][3:0]  packed BCD operand, digit 0 = least significant
//  bin_out  out  BIN_DIGITS      binary result (register)
//  done     out  1               one-cycle pulse: bin_out valid
//  rdy      out  1               high in IDLE, able to accept start
//  err      out  1               invalid-digit flag (present only with BCD2BIN_CHECK_EN)
// BEHAVIOUR
//  Reset: state=IDLE, bcd_reg=0, bin_reg=0, n_reg=0 -> bin_out=0, done=0, rdy=1, err=0.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: start=1 -> bcd_reg<=bcd_in, bin_reg<=0, n_reg<=BIN_DIGITS, go CALC; else hold.
//   CALC: every cycle, one shift step (below); n_reg<=n_reg-1; when n_reg-1==0 go DONE.
//   DONE: one cycle, done=1; unconditionally return to IDLE; start in DONE is ignored.
//  Shift step, computed on the concatenation {bcd_reg, bin_reg} shifted right by 1:
//   bin_next = {bcd_reg[0][0], bin_reg[BIN_DIGITS-1:1]}
//   sh[i] = {bcd_reg[i+1][0], bcd_reg[i][3:1]} for i<BCD_DIGITS-1; sh[top] = {1'b0, bcd_reg[top][3:1]}
//   bcd_next[i] = (sh[i] >= 8) ? sh[i]-3 : sh[i]  (4-bit subtract, per digit, after shift)
//  Latency: start sampled at edge T -> CALC for BIN_DIGITS cycles -> done high in cycle T+BIN_DIGITS+1.
//   Throughput: one conversion per BIN_DIGITS+2 cycles (IDLE visit mandatory between runs).
//  bin_out = bin_reg; it is only guaranteed valid while done=1 and holds until the next accepted start.
//   During CALC bin_out shows partial shift values; consumers must qualify on done.
//  bcd_in is captured once at start; later changes to bcd_in do not affect the running conversion.
//  start held high continuously: a new conversion begins from each IDLE visit (back-to-back).
//  For all valid inputs bcd_reg reaches 0 after BIN_DIGITS shifts; max input (all 9s) fits BIN_DIGITS.
//  arst_n asserted mid-CALC: immediate abort to reset values; no done pulse for the aborted run.
//  Invalid digits (>9) without the check: deterministic but meaningless result; no flag.
// CONFIGURATION
//  BCD2BIN_CHECK_EN defined: err port exists; at accepted start err<=|(any bcd_in digit > 9);
//   err holds until the next accepted start; conversion still runs full length, done still pulses.
//  BCD2BIN_CHECK_EN undefined: no err port, no digit comparators; all other behaviour identical.
// TESTING (BCD_DIGITS=4, BIN_DIGITS=14)
//  After reset: rdy=1, done=0, bin_out=0; start=1 with bcd_in=16'h0000 -> done at T+15, bin_out=0.
//  bcd_in=16'h1234, start pulse -> done exactly 15 cycles after start edge, bin_out=14'h04D2 (1234).
//  bcd_in=16'h9999 -> bin_out=14'h270F (9999); bcd_in=16'h0001 -> 1; bcd_in=16'h1000 -> 14'h03E8.
//  start pulsed and bcd_in changed during CALC -> ignored; single done, result from captured operand.
//  arst_n low at cycle 5 of CALC -> rdy=1, done never pulses, bin_out=0; next start converts normally.
//  With BCD2BIN_CHECK_EN: bcd_in=16'h12A4 -> err=1 at cycle after start, done still at T+15;
//   next start with 16'h0042 -> err=0, bin_out=42. Random sweep 0..9999 vs reference model, all match.

Source files
------------

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double-dabble).
// Each CALC cycle shifts {bcd, bin} right by one bit, then subtracts 3 from
// every BCD digit that reached 8 or more. After BIN_DIGITS shifts the binary
// result sits in bin_q.
// Optional feature: define BCD2BIN_CHECK_EN to add the err output. err flags
// any input digit greater than 9 at the accepted start.
module bcd_to_bin #(
  parameter  int BCD_DIGITS = 4,
  localparam int BIN_DIGITS = (BCD_DIGITS * 3322 + 999) / 1000,
  localparam int CNT_W      = $clog2(BIN_DIGITS + 1)
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        start,
  input  logic [BCD_DIGITS-1:0][3:0]  bcd_in,
  output logic [BIN_DIGITS-1:0]       bin_out,
  output logic                        done,
`ifdef BCD2BIN_CHECK_EN
  output logic                        err,
`endif
  output logic                        rdy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [BCD_DIGITS-1:0][3:0]   bcd_q, bcd_d;
  logic [BIN_DIGITS-1:0]        bin_q, bin_d;
  logic [CNT_W-1:0]             n_q, n_d;

  logic [BCD_DIGITS*4-1:0]      bcd_sh;
  logic [BCD_DIGITS-1:0][3:0]   bcd_step;
  logic [BIN_DIGITS-1:0]        bin_step;
  logic [3:0]                   dig;
  logic                         accept;
  logic                         last_step;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_step = (n_q == CNT_W'(1));

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      n_q     <= n_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One reverse double-dabble step: the bcd digits shift right as one vector
  // (the top digit takes in a 0), then each digit that is 8 or more gets 3 subtracted
  always_comb begin
    bcd_sh   = bcd_q >> 1;
    bin_step = {bcd_q[0][0], bin_q[BIN_DIGITS-1:1]};
    bcd_step = '0;
    dig      = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      dig         = bcd_sh[4*i +: 4];
      bcd_step[i] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
    end
  end

  // Datapath register inputs: load on an accepted start, step while in CALC
  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    n_d   = n_q;
    if (accept) begin
      bcd_d = bcd_in;
      bin_d = '0;
      n_d   = CNT_W'(BIN_DIGITS);
    end else if (state_q == S_CALC) begin
      bcd_d = bcd_step;
      bin_d = bin_step;
      n_d   = n_q - CNT_W'(1);
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic err_q, err_d;
  logic digit_bad;

  // Flag any operand digit above 9
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_in[i] > 4'd9) digit_bad = 1'b1;
    end
  end

  // err updates only on an accepted start and holds otherwise
  always_comb begin
    err_d = err_q;
    if (accept) err_d = digit_bad;
  end

  // err register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err = err_q;
`endif

  // FSM outputs
  always_comb begin
    rdy     = (state_q == S_IDLE);
    done    = (state_q == S_DONE);
    bin_out = bin_q;
  end

endmodule
